// File: rtl/slice_pkg.sv
// Shared definitions for the bit-slice reader/collector pair:
// frame geometry, FSM state encoding and the slice-index type.
package slice_pkg;

   localparam int LANES = 64;
   localparam int WIDTH = 25;
   localparam int AW    = 6;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Slice index as seen on the wire; the collector's number input
   // uses the same type.
   typedef logic [31:0] slice_idx_t;

endpackage

// File: rtl/slice_mux.sv
// Selects bit plane (WIDTH-1-k) from every stored word.
// Ports: words (LANES x WIDTH array), k (plane index), slice (LANES bits).
module slice_mux #(
   parameter int LANES = 64,
   parameter int WIDTH = 25,
   parameter int KW    = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] words [LANES],
   input  logic [KW-1:0]    k,
   output logic [LANES-1:0] slice
);

   logic [KW-1:0] pos;

   // Slice 0 is the MSB plane.
   assign pos = KW'(WIDTH - 1) - k;

   always_comb begin
      slice = '0;
      for (int n = 0; n < LANES; n++) begin
         slice[n] = words[n][pos];
      end
   end

endmodule

// File: rtl/slice_stream_reader.sv
// Holds LANES words of WIDTH bits and streams them out as WIDTH
// bit-slices (MSB plane first) over a valid/ready handshake.
// Ports: clk, rst (async, active-high); wr_en/wr_addr/wr_data word
// load and start (both IDLE only); slice_ready in; slice_valid,
// slice_data, slice_num, busy, done out.
module slice_stream_reader #(
   parameter int LANES = slice_pkg::LANES,
   parameter int WIDTH = slice_pkg::WIDTH,
   parameter int AW    = slice_pkg::AW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [AW-1:0]        wr_addr,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic                 start,
   input  logic                 slice_ready,
   output logic                 slice_valid,
   output logic [LANES-1:0]     slice_data,
   output slice_pkg::slice_idx_t slice_num,
   output logic                 busy,
   output logic                 done
);

   import slice_pkg::*;

   localparam int KW = $clog2(WIDTH);
   localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [KW-1:0]    k;
   logic [WIDTH-1:0] words [LANES];
   logic [LANES-1:0] mux_slice;
   logic             wr_ok;

   assign wr_ok = wr_en && (32'(wr_addr) < LANES);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = STREAM;
         STREAM:  if (slice_ready && k == K_LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Plane counter: parked at 0 outside a frame so slice 0 is
   // ready on the first STREAM cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k <= '0;
      end else if (state != STREAM) begin
         k <= '0;
      end else if (slice_ready && k != K_LAST) begin
         k <= k + KW'(1);
      end
   end

   // Word store; writable only in IDLE so a running frame is frozen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < LANES; n++) begin
            words[n] <= '0;
         end
      end else if (state == IDLE) begin
         if (wr_ok) begin
            words[wr_addr] <= wr_data;
         end
      end
   end

   slice_mux #(
      .LANES (LANES),
      .WIDTH (WIDTH),
      .KW    (KW)
   ) u_mux (
      .words (words),
      .k     (k),
      .slice (mux_slice)
   );

   // Outputs depend only on registered state, counter and words,
   // so they hold steady while the sink stalls.
   always_comb begin
      slice_valid = (state == STREAM);
      busy        = (state == STREAM);
      done        = (state == DONE);
      slice_data  = slice_valid ? mux_slice : '0;
      slice_num   = slice_valid ? slice_idx_t'(k) : '0;
   end

endmodule

// File: tb/tb_slice_stream_reader.sv
// Randomized self-checking bench for slice_stream_reader against a
// word-array model and a slice-to-word rebuild.
module tb_slice_stream_reader;

   localparam int LANES = 64;
   localparam int WIDTH = 25;
   localparam int AW    = 6;
   localparam int BUDGET = 2000;

   logic             clk;
   logic             rst;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             start;
   logic             slice_ready;
   logic             slice_valid;
   logic [LANES-1:0] slice_data;
   logic [31:0]      slice_num;
   logic             busy;
   logic             done;

   int total;
   int bad;

   bit [WIDTH-1:0] mw [LANES];
   bit [LANES-1:0] cap_data [$];
   int             cap_num [$];
   int             done_cyc;
   int             done_cnt;
   int             acc_last_cyc;
   int             unstable;
   bit             timeout;
   int             restart_seen;

   slice_stream_reader dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .start       (start),
      .slice_ready (slice_ready),
      .slice_valid (slice_valid),
      .slice_data  (slice_data),
      .slice_num   (slice_num),
      .busy        (busy),
      .done        (done)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   function automatic bit [LANES-1:0] exp_slice(input int k);
      bit [LANES-1:0] s;
      s = '0;
      for (int n = 0; n < LANES; n++) s[n] = mw[n][WIDTH-1-k];
      return s;
   endfunction

   task automatic write_word(input int a, input bit [WIDTH-1:0] d);
      wr_en = 1; wr_addr = AW'(a); wr_data = d;
      @(posedge clk); #1;
      wr_en = 0;
      mw[a] = d;
   endtask

   // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random ready.
   // inject: at cycle 4 pulse a write to word 5 and a start.
   task automatic stream(input int mode, input bit inject);
      bit r, hold;
      bit [LANES-1:0] pd;
      logic [31:0] pn;
      int cyc;
      cap_data.delete(); cap_num.delete();
      done_cyc = -1; done_cnt = 0; acc_last_cyc = -1;
      unstable = 0; timeout = 0; hold = 0; restart_seen = 0;
      pd = '0; pn = '0;
      start = 1;
      @(posedge clk); #1;
      start = 0; wr_en = 0;
      cyc = 1;
      forever begin
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (hold && (slice_data !== pd || slice_num !== pn)) unstable++;
         if (done_cyc >= 0 && !done) break;
         if (cyc > BUDGET) begin timeout = 1; break; end
         case (mode)
            0:       r = 1;
            1:       r = (cyc % 3 == 1);
            default: r = 1'($urandom_range(0, 1));
         endcase
         slice_ready = r;
         if (inject && cyc == 4) begin
            wr_en = 1; wr_addr = 6'd5; wr_data = 25'h1FFFFFF; start = 1;
         end else begin
            wr_en = 0; start = 0;
         end
         if (slice_valid && r) begin
            cap_data.push_back(slice_data);
            cap_num.push_back(int'(slice_num));
            if (slice_num == 32'(WIDTH - 1)) acc_last_cyc = cyc;
         end
         hold = slice_valid && !r;
         pd = slice_data; pn = slice_num;
         @(posedge clk); #1;
         cyc++;
      end
      slice_ready = 0; wr_en = 0; start = 0;
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (slice_valid !== 1'b0) begin
         bad++; $display("FAIL reset_valid got=%0b want=0", slice_valid);
      end
      total++;
      if (slice_data !== '0) begin
         bad++; $display("FAIL reset_data got=%h want=0", slice_data);
      end
      total++;
      if (slice_num !== 32'd0) begin
         bad++; $display("FAIL reset_num got=%0d want=0", slice_num);
      end
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL reset_busy_done got=%b%b want=00", busy, done);
      end
      rst = 0;
      for (int n = 0; n < LANES; n++) mw[n] = '0;
      slice_ready = 1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (slice_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_ready got valid=%b busy=%b want=00",
                  slice_valid, busy);
      end
      slice_ready = 0;
   endtask

   task automatic check_frame(input string tag, input int want_done);
      total++;
      if (timeout || cap_num.size() != WIDTH) begin
         bad++;
         $display("FAIL %s_count got=%0d timeout=%0b want=%0d",
                  tag, cap_num.size(), timeout, WIDTH);
      end
      for (int i = 0; i < cap_num.size() && i < WIDTH; i++) begin
         total++;
         if (cap_num[i] != i || cap_data[i] !== exp_slice(i)) begin
            bad++;
            $display("FAIL %s_slice%0d got num=%0d data=%h want num=%0d data=%h",
                     tag, i, cap_num[i], cap_data[i], i, exp_slice(i));
         end
      end
      total++;
      if (done_cnt != 1) begin
         bad++; $display("FAIL %s_done_cnt got=%0d want=1", tag, done_cnt);
      end
      total++;
      if (want_done > 0 && done_cyc != want_done) begin
         bad++;
         $display("FAIL %s_done_cycle got=%0d want=%0d", tag, done_cyc, want_done);
      end else if (want_done <= 0 && done_cyc != acc_last_cyc + 1) begin
         bad++;
         $display("FAIL %s_done_after_last got=%0d want=%0d",
                  tag, done_cyc, acc_last_cyc + 1);
      end
   endtask

   task automatic test_zero_frame;
      stream(0, 0);
      check_frame("zero", WIDTH + 1);
   endtask

   task automatic test_corner_words;
      bit [LANES-1:0] lo, hi;
      lo = 64'h0000000000000001;
      hi = 64'h8000000000000000;
      write_word(0, 25'h1000000);
      write_word(63, 25'h0000001);
      stream(0, 0);
      check_frame("corner", WIDTH + 1);
      total++;
      if (cap_data.size() != WIDTH || cap_data[0] !== lo
          || cap_data[WIDTH-1] !== hi) begin
         bad++;
         $display("FAIL corner_ends got=%h/%h want=%h/%h",
                  cap_data[0], cap_data[cap_data.size()-1], lo, hi);
      end
   endtask

   task automatic test_round_trip;
      bit [WIDTH-1:0] rec [LANES];
      for (int n = 0; n < LANES; n++) write_word(n, WIDTH'($urandom));
      stream(2, 0);
      check_frame("rtrip", 0);
      for (int n = 0; n < LANES; n++) rec[n] = '0;
      for (int i = 0; i < cap_num.size(); i++)
         if (cap_num[i] >= 0 && cap_num[i] < WIDTH)
            for (int n = 0; n < LANES; n++)
               rec[n][WIDTH-1-cap_num[i]] = cap_data[i][n];
      for (int n = 0; n < LANES; n++) begin
         total++;
         if (rec[n] !== mw[n]) begin
            bad++;
            $display("FAIL rtrip_word%0d got=%h want=%h", n, rec[n], mw[n]);
         end
      end
   endtask

   task automatic test_backpressure;
      stream(1, 0);
      check_frame("bp", 0);
      total++;
      if (unstable != 0) begin
         bad++; $display("FAIL bp_stable got=%0d changes want=0", unstable);
      end
   endtask

   task automatic test_start_with_write;
      bit [WIDTH-1:0] d;
      d = WIDTH'($urandom) | 25'h1000000;
      wr_en = 1; wr_addr = 6'd7; wr_data = d;
      mw[7] = d;
      stream(0, 0);
      check_frame("startwr", WIDTH + 1);
   endtask

   task automatic test_reset_mid;
      int cyc;
      int dn;
      bit hit;
      hit = 0;
      start = 1; slice_ready = 1;
      @(posedge clk); #1;
      start = 0;
      for (cyc = 0; cyc < 100; cyc++) begin
         if (slice_valid && slice_num == 32'd10) begin hit = 1; break; end
         @(posedge clk); #1;
      end
      total++;
      if (!hit) begin
         bad++; $display("FAIL rstmid_reach got=timeout want=slice10");
      end
      rst = 1;
      #1;
      total++;
      if (slice_valid !== 0 || slice_data !== '0 || slice_num !== 0
          || busy !== 0 || done !== 0) begin
         bad++;
         $display("FAIL rstmid_outputs got v=%b d=%h n=%0d b=%b dn=%b want=0",
                  slice_valid, slice_data, slice_num, busy, done);
      end
      @(posedge clk); #1;
      rst = 0;
      for (int n = 0; n < LANES; n++) mw[n] = '0;
      dn = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (done) dn++;
      end
      total++;
      if (dn != 0) begin
         bad++; $display("FAIL rstmid_no_done got=%0d pulses want=0", dn);
      end
      slice_ready = 0;
      stream(0, 0);
      check_frame("rstmid_restart", WIDTH + 1);
   endtask

   task automatic test_frozen;
      for (int j = 0; j < 4; j++) write_word($urandom_range(0, 63), WIDTH'($urandom));
      write_word(5, 25'h0AAAAAA);
      stream(0, 1);
      check_frame("frozen_run", WIDTH + 1);
      stream(0, 0);
      check_frame("frozen_rerun", WIDTH + 1);
      total++;
      if (cap_data.size() == WIDTH
          && cap_data[WIDTH-1][5] !== mw[5][0]) begin
         bad++;
         $display("FAIL frozen_word5 got=%b want=%b",
                  cap_data[WIDTH-1][5], mw[5][0]);
      end
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1; wr_en = 0; wr_addr = '0; wr_data = '0;
      start = 0; slice_ready = 0;
      test_reset;
      test_zero_frame;
      test_corner_words;
      test_round_trip;
      test_backpressure;
      test_start_with_write;
      test_reset_mid;
      test_frozen;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
